// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forward selects and mult/div tracker states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUOutM

  // Multi-cycle mult/div unit occupancy
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundles the pipeline-stage signals observed and driven by the hazard controller.
// Latency: n/a (wires only).
// Backpressure: stalls travel back to fetch/decode through StallF/StallD.
interface hazard_control_unit_if #(
  parameter int REG_ID_W = 5
);
  // Decode stage
  logic [REG_ID_W-1:0] RsD;
  logic [REG_ID_W-1:0] RtD;
  logic                BranchD;
  logic                MdReadD;
  // Execute stage
  logic [REG_ID_W-1:0] RsE;
  logic [REG_ID_W-1:0] RtE;
  logic [REG_ID_W-1:0] WriteRegE;
  logic                RegWriteE;
  logic                MemtoRegE;
  logic                MdStartE;
  logic                MdIsDivE;
  // Memory / writeback stages
  logic [REG_ID_W-1:0] WriteRegM;
  logic [REG_ID_W-1:0] WriteRegW;
  logic                RegWriteM;
  logic                RegWriteW;
  logic                MemtoRegM;
  // Controller outputs
  logic                StallF;
  logic                StallD;
  logic                FlushE;
  logic                ForwardAD;
  logic                ForwardBD;
  logic [1:0]          ForwardAE;
  logic [1:0]          ForwardBE;
  logic                MdBusy;

  // Pipeline side: drives stage state, consumes stall/forward controls
  modport master (
    output RsD, RtD, BranchD, MdReadD,
    output RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MdStartE, MdIsDivE,
    output WriteRegM, WriteRegW, RegWriteM, RegWriteW, MemtoRegM,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy
  );

  // Controller side
  modport slave (
    input  RsD, RtD, BranchD, MdReadD,
    input  RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MdStartE, MdIsDivE,
    input  WriteRegM, WriteRegW, RegWriteM, RegWriteW, MemtoRegM,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy
  );

endinterface

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the multi-cycle MULT/DIV unit with a loadable down-counter.
// Latency: MdBusy rises the clock after MdStartE, stays high for MUL_CYCLES or DIV_CYCLES clocks.
// Backpressure: none here; starts arriving while busy (except on the final cycle) are ignored.
module md_busy_tracker #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic MdStartE,
  input  logic MdIsDivE,
  output logic MdBusy
);
  import hazard_pkg::*;

  // Counter holds the number of busy cycles still to come after the current one
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdState_t         state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;

  // State and counter registers; reset aborts any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Next-state: load on start, count down while busy, allow back-to-back on the last cycle
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (MdStartE) begin
          stateNxt = MD_BUSY;
          cntNxt   = MdIsDivE ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          cntNxt = cnt - CNT_W'(1);
        end else if (MdStartE) begin
          cntNxt = MdIsDivE ? DIV_LOAD : MUL_LOAD;
        end else begin
          stateNxt = MD_IDLE;
        end
      end
      default: begin
        stateNxt = MD_IDLE;
        cntNxt   = '0;
      end
    endcase
  end

  assign MdBusy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_control_unit.sv
// Forwarding selects and stall/flush generation for the 5-stage MIPS pipeline.
// Latency: all controls are combinational from the current stage state (zero cycles).
// Backpressure: a single stall holds PC and F/D and bubbles E until every cause clears.
module hazard_control_unit #(
  parameter int REG_ID_W   = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int FORWARD_EN = 1
) (
  input logic             clock,
  input logic             reset,
  hazard_control_unit_if.slave hz
);
  import hazard_pkg::*;

  // Register $0 is hard-wired zero and never creates a dependency
  function automatic logic regHit(input logic [REG_ID_W-1:0] a, input logic [REG_ID_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic       mdBusy;
  logic       lwStall, branchStall, mdStall, rawStall, stall;
  logic [1:0] fwdAE, fwdBE;
  logic       fwdAD, fwdBD;

  md_busy_tracker #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) uTracker (
    .clock    (clock),
    .reset    (reset),
    .MdStartE (hz.MdStartE),
    .MdIsDivE (hz.MdIsDivE),
    .MdBusy   (mdBusy)
  );

  // Forward selects: the younger M-stage result takes priority over W
  always_comb begin
    fwdAE = FWD_RF;
    fwdBE = FWD_RF;
    fwdAD = 1'b0;
    fwdBD = 1'b0;
    if (FORWARD_EN != 0 && !reset) begin
      if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RsE))      fwdAE = FWD_MEM;
      else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RsE)) fwdAE = FWD_WB;
      if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RtE))      fwdBE = FWD_MEM;
      else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RtE)) fwdBE = FWD_WB;
      fwdAD = hz.RegWriteM && regHit(hz.WriteRegM, hz.RsD);
      fwdBD = hz.RegWriteM && regHit(hz.WriteRegM, hz.RtD);
    end
  end

  // Stall causes are OR-ed so overlapping causes give one continuous stall, never a double bubble
  always_comb begin
    lwStall     = hz.MemtoRegE && (regHit(hz.RtE, hz.RsD) || regHit(hz.RtE, hz.RtD));
    branchStall = hz.BranchD &&
                  ((hz.RegWriteE && (regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD))) ||
                   (hz.MemtoRegM && (regHit(hz.WriteRegM, hz.RsD) || regHit(hz.WriteRegM, hz.RtD))));
    // MFHI/MFLO and a following mult/div both arrive on MdReadD
    mdStall     = mdBusy && hz.MdReadD;
    // Without forwarding any in-flight write to a decode source must drain first
    rawStall    = (hz.RegWriteE && (regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD))) ||
                  (hz.RegWriteM && (regHit(hz.WriteRegM, hz.RsD) || regHit(hz.WriteRegM, hz.RtD))) ||
                  (hz.RegWriteW && (regHit(hz.WriteRegW, hz.RsD) || regHit(hz.WriteRegW, hz.RtD)));
    stall       = lwStall || branchStall || mdStall || ((FORWARD_EN == 0) && rawStall);
    if (reset) stall = 1'b0;
  end

  assign hz.StallF    = stall;
  assign hz.StallD    = stall;
  assign hz.FlushE    = stall;
  assign hz.ForwardAE = fwdAE;
  assign hz.ForwardBE = fwdBE;
  assign hz.ForwardAD = fwdAD;
  assign hz.ForwardBD = fwdBD;
  assign hz.MdBusy    = mdBusy;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two controllers (forwarding on, long divide / forwarding off, short ops) on shared stimulus.
// Latency: expected values are queued per cycle and checked on the following falling edge.
// Backpressure: n/a.
module tb_hazard_control_unit;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic branchD, mdReadD, regWriteE, regWriteM, regWriteW;
    logic memtoRegE, memtoRegM, mdStartE, mdIsDivE, rst;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       stallA, fadA, fbdA, busyA;
    logic [1:0] faeA, fbeA;
    logic       stallB, fadB, fbdB, busyB;
    logic [1:0] faeB, fbeB;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hazard_control_unit_if #(.REG_ID_W(5)) ifA ();
  hazard_control_unit_if #(.REG_ID_W(5)) ifB ();

  hazard_control_unit #(
    .REG_ID_W(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .FORWARD_EN(1)
  ) dutA (.clock(clock), .reset(reset), .hz(ifA));

  hazard_control_unit #(
    .REG_ID_W(5), .MUL_CYCLES(2), .DIV_CYCLES(3), .CNT_W(6), .FORWARD_EN(0)
  ) dutB (.clock(clock), .reset(reset), .hz(ifB));

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycNo  = 0;
  int   leftA  = 0;  // busy cycles remaining for each controller's mult/div unit
  int   leftB  = 0;

  // ---------------- reference model ----------------
  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] exFwd(input stim_t s, input logic [4:0] src);
    if (s.regWriteM && dep(s.wrM, src)) return 2'b10;
    if (s.regWriteW && dep(s.wrW, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model(input stim_t s, input bit busyA, input bit busyB);
    exp_t e;
    bit lw, br, raw;
    lw  = s.memtoRegE && (dep(s.rtE, s.rsD) || dep(s.rtE, s.rtD));
    br  = s.branchD && ((s.regWriteE && (dep(s.wrE, s.rsD) || dep(s.wrE, s.rtD))) ||
                        (s.memtoRegM && (dep(s.wrM, s.rsD) || dep(s.wrM, s.rtD))));
    raw = 0;
    if (s.regWriteE && (dep(s.wrE, s.rsD) || dep(s.wrE, s.rtD))) raw = 1;
    if (s.regWriteM && (dep(s.wrM, s.rsD) || dep(s.wrM, s.rtD))) raw = 1;
    if (s.regWriteW && (dep(s.wrW, s.rsD) || dep(s.wrW, s.rtD))) raw = 1;
    e.cyc    = cycNo;
    e.busyA  = busyA;
    e.busyB  = busyB;
    e.stallA = !s.rst && (lw || br || (busyA && s.mdReadD));
    e.stallB = !s.rst && (lw || br || raw || (busyB && s.mdReadD));
    e.faeA   = s.rst ? 2'b00 : exFwd(s, s.rsE);
    e.fbeA   = s.rst ? 2'b00 : exFwd(s, s.rtE);
    e.fadA   = !s.rst && s.regWriteM && dep(s.wrM, s.rsD);
    e.fbdA   = !s.rst && s.regWriteM && dep(s.wrM, s.rtD);
    e.faeB   = 2'b00;
    e.fbeB   = 2'b00;
    e.fadB   = 1'b0;
    e.fbdB   = 1'b0;
    return e;
  endfunction

  // A new op is accepted when idle or on the last busy cycle; otherwise time just runs down
  function automatic int nextLeft(input int left, input bit start, input int len);
    if (start && left <= 1) return len;
    if (left > 0) return left - 1;
    return 0;
  endfunction

  // ---------------- stimulus ----------------
  function automatic stim_t idle();
    stim_t s;
    s.rsD = 0; s.rtD = 0; s.rsE = 0; s.rtE = 0; s.wrE = 0; s.wrM = 0; s.wrW = 0;
    s.branchD = 0; s.mdReadD = 0; s.regWriteE = 0; s.regWriteM = 0; s.regWriteW = 0;
    s.memtoRegE = 0; s.memtoRegM = 0; s.mdStartE = 0; s.mdIsDivE = 0; s.rst = 0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rsD = 5'($urandom_range(0, 7)); s.rtD = 5'($urandom_range(0, 7));
    s.rsE = 5'($urandom_range(0, 7)); s.rtE = 5'($urandom_range(0, 7));
    s.wrE = 5'($urandom_range(0, 7)); s.wrM = 5'($urandom_range(0, 7));
    s.wrW = 5'($urandom_range(0, 7));
    s.branchD   = ($urandom_range(0, 3) == 0);
    s.mdReadD   = ($urandom_range(0, 3) == 0);
    s.regWriteE = $urandom_range(0, 1) != 0;
    s.regWriteM = $urandom_range(0, 1) != 0;
    s.regWriteW = $urandom_range(0, 1) != 0;
    s.memtoRegE = ($urandom_range(0, 3) == 0);
    s.memtoRegM = ($urandom_range(0, 3) == 0);
    s.mdStartE  = ($urandom_range(0, 11) == 0);
    s.mdIsDivE  = $urandom_range(0, 1) != 0;
    s.rst       = ($urandom_range(0, 299) == 0);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ifA.RsD = s.rsD; ifA.RtD = s.rtD; ifA.RsE = s.rsE; ifA.RtE = s.rtE;
    ifA.WriteRegE = s.wrE; ifA.WriteRegM = s.wrM; ifA.WriteRegW = s.wrW;
    ifA.BranchD = s.branchD; ifA.MdReadD = s.mdReadD;
    ifA.RegWriteE = s.regWriteE; ifA.RegWriteM = s.regWriteM; ifA.RegWriteW = s.regWriteW;
    ifA.MemtoRegE = s.memtoRegE; ifA.MemtoRegM = s.memtoRegM;
    ifA.MdStartE = s.mdStartE; ifA.MdIsDivE = s.mdIsDivE;
    ifB.RsD = s.rsD; ifB.RtD = s.rtD; ifB.RsE = s.rsE; ifB.RtE = s.rtE;
    ifB.WriteRegE = s.wrE; ifB.WriteRegM = s.wrM; ifB.WriteRegW = s.wrW;
    ifB.BranchD = s.branchD; ifB.MdReadD = s.mdReadD;
    ifB.RegWriteE = s.regWriteE; ifB.RegWriteM = s.regWriteM; ifB.RegWriteW = s.regWriteW;
    ifB.MemtoRegE = s.memtoRegE; ifB.MemtoRegM = s.memtoRegM;
    ifB.MdStartE = s.mdStartE; ifB.MdIsDivE = s.mdIsDivE;
    reset = s.rst;
  endtask

  // One pipeline cycle: drive just after the rising edge, queue the expectation, advance the model
  task automatic step(input stim_t s);
    apply(s);
    if (s.rst) begin
      leftA = 0;
      leftB = 0;
    end
    expQ.push_back(model(s, leftA > 0, leftB > 0));
    @(posedge clock);
    if (!s.rst) begin
      leftA = nextLeft(leftA, s.mdStartE, s.mdIsDivE ? 32 : 4);
      leftB = nextLeft(leftB, s.mdStartE, s.mdIsDivE ? 3 : 2);
    end
    #1;
    cycNo++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int cyc, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0b expected=%0b", name, cyc, act, exp);
    end
  endtask

  // Outputs are combinational, so every cycle presents a result; sample mid-cycle
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("A.StallF",    e.cyc, {1'b0, ifA.StallF},    {1'b0, e.stallA});
      check("A.StallD",    e.cyc, {1'b0, ifA.StallD},    {1'b0, e.stallA});
      check("A.FlushE",    e.cyc, {1'b0, ifA.FlushE},    {1'b0, e.stallA});
      check("A.ForwardAE", e.cyc, ifA.ForwardAE,         e.faeA);
      check("A.ForwardBE", e.cyc, ifA.ForwardBE,         e.fbeA);
      check("A.ForwardAD", e.cyc, {1'b0, ifA.ForwardAD}, {1'b0, e.fadA});
      check("A.ForwardBD", e.cyc, {1'b0, ifA.ForwardBD}, {1'b0, e.fbdA});
      check("A.MdBusy",    e.cyc, {1'b0, ifA.MdBusy},    {1'b0, e.busyA});
      check("B.StallF",    e.cyc, {1'b0, ifB.StallF},    {1'b0, e.stallB});
      check("B.StallD",    e.cyc, {1'b0, ifB.StallD},    {1'b0, e.stallB});
      check("B.FlushE",    e.cyc, {1'b0, ifB.FlushE},    {1'b0, e.stallB});
      check("B.ForwardAE", e.cyc, ifB.ForwardAE,         e.faeB);
      check("B.ForwardBE", e.cyc, ifB.ForwardBE,         e.fbeB);
      check("B.ForwardAD", e.cyc, {1'b0, ifB.ForwardAD}, {1'b0, e.fadB});
      check("B.ForwardBD", e.cyc, {1'b0, ifB.ForwardBD}, {1'b0, e.fbdB});
      check("B.MdBusy",    e.cyc, {1'b0, ifB.MdBusy},    {1'b0, e.busyB});
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    stim_t s;
    apply(idle());
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset state
    s = idle(); s.rst = 1; s.mdReadD = 1; s.memtoRegE = 1; s.rtE = 5; s.rsD = 5;
    step(s);
    step(s);

    // Forward priority: M over W, then W alone, then $0 source
    s = idle(); s.rsE = 3; s.wrM = 3; s.regWriteM = 1; s.wrW = 3; s.regWriteW = 1;
    step(s);
    s.regWriteM = 0;
    step(s);
    s.regWriteM = 1; s.rsE = 0;
    step(s);

    // Load-use stall followed by release
    s = idle(); s.memtoRegE = 1; s.rtE = 5; s.rsD = 5;
    step(s);
    s.memtoRegE = 0;
    step(s);

    // Branch depending on an E-stage ALU result, then forwarded from M
    s = idle(); s.branchD = 1; s.rsD = 7; s.regWriteE = 1; s.wrE = 7;
    step(s);
    s = idle(); s.branchD = 1; s.rsD = 7; s.regWriteM = 1; s.wrM = 7;
    step(s);

    // No-forward controller: pending M write to a decode source
    s = idle(); s.regWriteM = 1; s.wrM = 4; s.rsD = 4; s.rsE = 4;
    step(s);

    // Divide with a dependent MFHI held in decode across the whole operation
    s = idle(); s.mdStartE = 1; s.mdIsDivE = 1;
    step(s);
    s = idle(); s.mdReadD = 1;
    for (int i = 0; i < 34; i++) step(s);

    // Back-to-back multiplies: second start lands on the last busy cycle
    s = idle(); s.mdStartE = 1;
    step(s);
    s = idle();
    for (int i = 0; i < 3; i++) step(s);
    s.mdStartE = 1; s.mdReadD = 1;
    step(s);
    s = idle(); s.mdReadD = 1;
    for (int i = 0; i < 5; i++) step(s);

    // Reset ten cycles into a divide: busy must drop before the next clock edge
    s = idle(); s.mdStartE = 1; s.mdIsDivE = 1;
    step(s);
    s = idle();
    for (int i = 0; i < 10; i++) step(s);
    s = idle(); s.rst = 1; s.mdReadD = 1;
    step(s);
    s = idle(); s.mdReadD = 1;
    step(s);
    step(s);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) step(rnd());

    s = idle();
    step(s);
    @(negedge clock);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
